// File: rtl/aes_mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns sequencer.
//
// A 128-bit state block and a direction flag are accepted over a valid/ready handshake. The
// block is then transformed in place, COLS_PER_CYCLE columns per clock, by a shared word-wide
// GF(2^8) matrix unit, and the result is offered on a valid/ready output.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input block offered
//   in_ready_o   sequencer can accept a block this cycle
//   in_enc_i     1 = forward MixColumns, 0 = InvMixColumns (sampled at the input handshake)
//   in_block_i   input state block; column c at [32c+31:32c], row 0 is the low byte of a column
//   out_valid_o  result block available
//   out_ready_i  consumer accepts the result
//   out_block_o  result state block (zero unless out_valid_o is high)
//   busy_o       a block is being transformed or waiting to be drained
module aes_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter int unsigned BLOCK_W        = 128
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_enc_i,
  input  logic [BLOCK_W-1:0] in_block_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BLOCK_W-1:0] out_block_o,
  output logic               busy_o
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cols
    $fatal(1, "aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  if (BLOCK_W != 128) begin : gen_bad_width
    $fatal(1, "aes_mix_columns_seq: BLOCK_W must be 128");
  end

  // The 2-bit column counter wraps naturally; with 4 columns per cycle it never moves.
  localparam logic [1:0] CntStep = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LastCnt = 2'((4 - COLS_PER_CYCLE) % 4);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic                 enc_q, enc_d;

  // Multiply by 02 in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix. Each matrix row is the first row rotated
  // right by the row index, so row r weights byte (r+k)%4 with the k-th first-row coefficient.
  function automatic logic [31:0] mix_word(input logic [31:0] w, input logic enc);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [1:0]  k0, k1, k2, k3;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[8*i +: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      k0 = 2'(i);
      k1 = k0 + 2'd1;
      k2 = k0 + 2'd2;
      k3 = k0 + 2'd3;
      if (enc) begin
        // 02 03 01 01
        r[8*i +: 8] = x2[k0] ^ x2[k1] ^ a[k1] ^ a[k2] ^ a[k3];
      end else begin
        // 0E 0B 0D 09
        r[8*i +: 8] = (x8[k0] ^ x4[k0] ^ x2[k0]) ^ (x8[k1] ^ x2[k1] ^ a[k1]) ^
                      (x8[k2] ^ x4[k2] ^ a[k2])  ^ (x8[k3] ^ a[k3]);
      end
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      block_q <= '0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      enc_q   <= enc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    logic [1:0] col;
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    enc_d   = enc_q;
    col     = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = StBusy;
          cnt_d   = '0;
          block_d = in_block_i;
          enc_d   = in_enc_i;
        end
      end
      StBusy: begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          col = cnt_q + 2'(k);
          block_d[32*col +: 32] = mix_word(block_q[32*col +: 32], enc_q);
        end
        cnt_d = cnt_q + CntStep;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          // Drain and fill on the same edge keeps back-to-back blocks free of an idle cycle.
          if (in_valid_i) begin
            state_d = StBusy;
            cnt_d   = '0;
            block_d = in_block_i;
            enc_d   = in_enc_i;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs. in_ready_o never depends on in_valid_i.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    out_block_o = '0;
    unique case (state_q)
      StIdle: in_ready_o = 1'b1;
      StBusy: busy_o = 1'b1;
      StDone: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        out_block_o = block_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench for aes_mix_columns_seq: three instances (1, 2 and 4 columns per cycle),
// a reference model built on a generic GF(2^8) multiply, and a queue of expected results.
module tb_aes_mix_columns_seq;

  localparam int Budget = 100;
  localparam logic [127:0] VecIn  = {32'hD5D4D4D4, 32'h01010101, 32'h0A0A0A0A, 32'h455313DB};
  localparam logic [127:0] VecOut = {32'hD6D7D5D5, 32'h01010101, 32'h0A0A0A0A, 32'hBCA14D8E};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         in_enc    [3];
  logic [127:0] in_block  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_block [3];
  logic         busy      [3];

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_enc_i(in_enc[0]), .in_block_i(in_block[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_block_o(out_block[0]), .busy_o(busy[0])
  );

  aes_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_enc_i(in_enc[1]), .in_block_i(in_block[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_block_o(out_block[1]), .busy_o(busy[1])
  );

  aes_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_enc_i(in_enc[2]), .in_block_i(in_block[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .out_block_o(out_block[2]), .busy_o(busy[2])
  );

  // Reference model: schoolbook GF(2^8) multiply against the full matrices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] b, input logic enc);
    logic [7:0]   m [16];
    logic [7:0]   acc;
    logic [127:0] res;
    if (enc) m = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
                   8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
    else     m = '{8'h0E, 8'h0B, 8'h0D, 8'h09, 8'h09, 8'h0E, 8'h0B, 8'h0D,
                   8'h0D, 8'h09, 8'h0E, 8'h0B, 8'h0B, 8'h0D, 8'h09, 8'h0E};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[4*r+j], b[32*c+8*j +: 8]);
        res[32*c+8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one block and wait (bounded) for acceptance; expected result queued on acceptance.
  task automatic drive_block(input int d, input logic [127:0] b, input logic e, input int gap);
    int t;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    in_valid[d] = 1'b1; in_block[d] = b; in_enc[d] = e;
    t = 0;
    @(negedge clk);
    while (in_ready[d] !== 1'b1 && t < Budget) begin @(negedge clk); t++; end
    if (in_ready[d] !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b after %0d cycles, required 1", d,
               in_ready[d], Budget);
      in_valid[d] = 1'b0;
      return;
    end
    exp_q.push_back(ref_mix(b, e));
    @(posedge clk); #1;
    in_valid[d] = 1'b0; in_block[d] = rand_block(); in_enc[d] = $urandom_range(0, 1) == 1;
  endtask

  // Accept one result (bounded wait) and compare it against the scoreboard.
  task automatic collect(input int d, input int gap, output logic [127:0] got, output bit ok);
    int t;
    logic [127:0] want;
    ok = 1'b0; got = '0;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    out_ready[d] = 1'b1;
    t = 0;
    @(negedge clk);
    while (out_valid[d] !== 1'b1 && t < Budget) begin @(negedge clk); t++; end
    n_checks++;
    if (out_valid[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL result_timeout dut%0d: out_valid=%b after %0d cycles, required 1", d,
               out_valid[d], Budget);
      out_ready[d] = 1'b0;
      return;
    end
    got = out_block[d];
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_extra dut%0d: got %h, required no result", d, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_errors++;
        $display("FAIL scoreboard dut%0d: got %h, required %h", d, got, want);
      end
    end
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    ok = 1'b1;
  endtask

  // Offer a block and wait for out_valid without draining it.
  task automatic start_and_wait(input int d, input logic [127:0] b, input logic e);
    int t;
    drive_block(d, b, e, 0);
    t = 0;
    while (out_valid[d] !== 1'b1 && t < Budget) begin @(posedge clk); #1; t++; end
    if (out_valid[d] !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout dut%0d: out_valid=%b, required 1", d, out_valid[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || out_block[d] !== '0 ||
          in_ready[d] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_state dut%0d: valid=%b busy=%b ready=%b block=%h, required 0 0 1 0",
                 d, out_valid[d], busy[d], in_ready[d], out_block[d]);
      end
    end
  endtask

  // Single block through an idle DUT: latency, busy/ready while working, result, return to idle.
  task automatic test_transform(input int d, input logic [127:0] b, input logic e,
                                input int lat_exp, input logic [127:0] blk_exp, input string tag);
    int lat;
    logic [127:0] want;
    in_valid[d] = 1'b1; in_block[d] = b; in_enc[d] = e;
    @(negedge clk);
    n_checks++;
    if (in_ready[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_idle_ready: in_ready=%b, required 1", tag, in_ready[d]);
    end
    exp_q.push_back(ref_mix(b, e));
    @(posedge clk); #1;
    in_valid[d] = 1'b0; in_block[d] = rand_block(); in_enc[d] = ~e;
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < Budget) begin
      n_checks++;
      if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_busy: busy=%b in_ready=%b, required 1 0", tag, busy[d], in_ready[d]);
      end
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== lat_exp) begin
      n_errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, lat_exp);
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    n_checks++;
    if (out_block[d] !== want) begin
      n_errors++;
      $display("FAIL %s_model: got %h, required %h", tag, out_block[d], want);
    end
    n_checks++;
    if (out_block[d] !== blk_exp) begin
      n_errors++;
      $display("FAIL %s_vector: got %h, required %h", tag, out_block[d], blk_exp);
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    n_checks++;
    if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_back_to_idle: valid=%b busy=%b ready=%b, required 0 0 1", tag,
               out_valid[d], busy[d], in_ready[d]);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] want;
    start_and_wait(0, VecIn, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = $urandom_range(0, 1) == 1;
      in_block[0] = rand_block();
      in_enc[0]   = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid[0] !== 1'b1 || out_block[0] !== VecOut || in_ready[0] !== 1'b0 ||
          busy[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_hold cycle %0d: valid=%b ready=%b busy=%b block=%h, required 1 0 1 %h",
                 i, out_valid[0], in_ready[0], busy[0], out_block[0], VecOut);
      end
    end
    in_valid[0] = 1'b0;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_block[0] !== want) begin
      n_errors++;
      $display("FAIL stall_result: got %h, required %h", out_block[0], want);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_drain: valid=%b ready=%b, required 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] want;
    start_and_wait(0, VecIn, 1'b1);
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1; in_block[0] = VecOut; in_enc[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_ready: in_ready=%b with out_ready=1 in DONE, required 1", in_ready[0]);
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    n_checks++;
    if (out_block[0] !== want) begin
      n_errors++;
      $display("FAIL drain_result: got %h, required %h", out_block[0], want);
    end
    exp_q.push_back(ref_mix(VecOut, 1'b0));
    @(posedge clk); #1;
    out_ready[0] = 1'b0; in_valid[0] = 1'b0; in_block[0] = rand_block();
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_busy: valid=%b busy=%b ready=%b, required 0 1 0", out_valid[0],
               busy[0], in_ready[0]);
    end
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < Budget) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== 4) begin
      n_errors++;
      $display("FAIL fill_latency: got %0d cycles, required 4", lat);
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    n_checks++;
    if (out_block[0] !== VecIn || out_block[0] !== want) begin
      n_errors++;
      $display("FAIL fill_result: got %h, required %h", out_block[0], VecIn);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    in_valid[0] = 1'b1; in_block[0] = rand_block(); in_enc[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    n_checks++;
    if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_abort: busy=%b valid=%b, required 1 0", busy[0], out_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_block[0] !== '0 ||
        in_ready[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_state: valid=%b busy=%b ready=%b block=%h, required 0 0 1 0",
               out_valid[0], busy[0], in_ready[0], out_block[0]);
    end
    exp_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_transform(0, VecIn, 1'b1, 4, VecOut, "post_reset");
  endtask

  // Random blocks forward, then the results inverse; every original must come back in order.
  task automatic test_random_roundtrip(input int d, input int n, input int gap);
    logic [127:0] p [];
    logic [127:0] f [];
    p = new[n];
    f = new[n];
    for (int i = 0; i < n; i++) begin p[i] = rand_block(); f[i] = '0; end
    for (int pass = 0; pass < 2; pass++) begin
      fork
        begin
          for (int i = 0; i < n; i++) drive_block(d, (pass == 0) ? p[i] : f[i], pass == 0, gap);
        end
        begin
          logic [127:0] got;
          bit ok;
          for (int i = 0; i < n; i++) begin
            collect(d, gap, got, ok);
            if (!ok) break;
            if (pass == 0) f[i] = got;
            else begin
              n_checks++;
              if (got !== p[i]) begin
                n_errors++;
                $display("FAIL roundtrip dut%0d block %0d: got %h, required %h", d, i, got, p[i]);
              end
            end
          end
        end
      join
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
      n_errors++;
      $display("FAIL roundtrip_leftover dut%0d: queued=%0d valid=%b busy=%b, required 0 0 0", d,
               exp_q.size(), out_valid[d], busy[d]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_enc[d] = 1'b0; in_block[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_transform(0, VecIn,  1'b1, 4, VecOut, "fwd_c1");
    test_transform(0, VecOut, 1'b0, 4, VecIn,  "inv_c1");
    test_transform(1, VecIn,  1'b1, 2, VecOut, "fwd_c2");
    test_transform(1, VecOut, 1'b0, 2, VecIn,  "inv_c2");
    test_transform(2, VecIn,  1'b1, 1, VecOut, "fwd_c4");
    test_transform(2, VecOut, 1'b0, 1, VecIn,  "inv_c4");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_random_roundtrip(0, 1000, 3);
    test_random_roundtrip(1, 100, 2);
    test_random_roundtrip(2, 100, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_seq.md
Name: aes_mix_columns_seq

Overview:
Column-serial sequencer for the AES MixColumns / InvMixColumns transform. It accepts a 128-bit state block and a direction flag over a valid/ready handshake. It then drives a shared word-wide GF(2^8) matrix unit over the block's four columns, COLS_PER_CYCLE columns per clock, and presents the result on a valid/ready output. It sits between the round's ShiftRows stage and AddRoundKey in area-reduced cores, replacing the fully parallel 4-column combinational MixColumns.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2 or 4; any other value is an elaboration error.
BLOCK_W, 128, block width in bits; fixed at 128.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block offered
in_ready  out  1  sequencer can accept a block this cycle
in_enc  in  1  1 = forward MixColumns, 0 = InvMixColumns; sampled at input handshake
in_block  in  128  input state block
out_valid  out  1  result block available
out_ready  in  1  consumer accepts the result
out_block  out  128  result state block
busy  out  1  high in BUSY or DONE

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low.
- Layout: column c occupies bits [32c+31:32c]. Row r of a column occupies bits [8r+7:8r] of that word, so row 0 is the low byte.
- Forward matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
- Inverse matrix rows: {0E 0B 0D 09}, {09 0E 0B 0D}, {0D 09 0E 0B}, {0B 0D 09 0E}.
- GF multiply by 02: shift left by one; if the old bit 7 was 1, XOR the result with 8'h1B. All arithmetic is 8-bit with no carry beyond bit 7.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Reset: state=IDLE; column counter=0; block register=0; enc register=0; out_valid=0; busy=0; out_block=0. Reset asserted mid-operation discards the block in flight. After reset release the block behaves as if fresh out of reset; no partial result is ever emitted.
- IDLE→BUSY: on a clock edge with in_valid & in_ready. That edge loads in_block into the block register, in_enc into the enc register, and sets the counter to 0.
- BUSY:
  - Each edge replaces columns counter .. counter+COLS_PER_CYCLE-1 in place with their transformed values, using the latched enc; the counter then advances by COLS_PER_CYCLE.
  - When the last column (3) is written, the next state is DONE and the counter wraps to 0.
- Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the accepting edge (4, 2 or 1).
- Throughput: one block per 4/COLS_PER_CYCLE + 1 cycles when back-to-back.
- DONE:
  - out_block = block register.
  - out_block and out_valid hold stable until out_valid & out_ready.
  - On that edge: if in_valid is also high, the new block is loaded and the next state is BUSY (simultaneous drain and fill); otherwise the next state is IDLE.
- Stall behaviour: in_enc and in_block changes are ignored outside the handshake edge. out_ready without out_valid has no effect.
- Combinational paths: no path from in_valid to in_ready. in_ready depends on out_ready in DONE only.

Test Plan:
1. Forward transform, COLS_PER_CYCLE=1:
   - Stimulus: in_enc=1, in_block columns {32'h455313DB, 32'h0A0A0A0A, 32'h01010101, 32'hD5D4D4D4} (column 0 to column 3).
   - Response: out_valid 4 cycles after accept; columns {32'hBCA14D8E, 32'h0A0A0A0A, 32'h01010101, 32'hD6D7D5D5}.
2. Inverse transform:
   - Stimulus: the output block of scenario 1 with in_enc=0.
   - Response: exactly the original input block. Repeat with COLS_PER_CYCLE=2 and 4; latency must be 2 and 1 cycles.
3. Backpressure:
   - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
   - Response: out_block stable, in_ready=0, busy=1; in_block changes during the stall are ignored.
4. Drain and fill on the same edge:
   - Stimulus: in DONE, assert out_ready=1 and in_valid=1 with a new block.
   - Response: old result consumed and new block accepted on the same edge; next result appears after the standard latency with no IDLE cycle.
5. Reset mid-BUSY:
   - Stimulus: assert rst_n=0 asynchronously at counter=2.
   - Response: out_valid=0, busy=0, out_block=0 immediately. After release, a fresh block with in_enc=1 produces a correct result with no leftover from the aborted block.
6. Randomised round-trip:
   - Stimulus: 1000 random blocks passed forward then inverse, with random valid/ready gaps.
   - Response: every block is returned bit-exact, in order, with no drops or duplicates.
